instr_sequencer: RTL and testbench

Program-feeding controller for the tiny accumulator core. Holds a small program in a register-file memory and issues one 6-bit instruction per cycle on the core's instr input. Follows the core's cjump flag to redirect its program counter. Sits between the tinytapeout pin shim and the core when the on-chip program mode is used instead of pin-driven instructions.

---
 rtl/jlc_seq_pkg.sv | 15 +
 rtl/instr_sequencer_if.sv | 33 +++
 rtl/instr_sequencer_prog_mem.sv | 27 ++
 rtl/instr_sequencer.sv | 125 ++++++++++++
 tb/tb_instr_sequencer.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/jlc_seq_pkg.sv
// Shared types and constants for the on-chip program sequencer and the core wrapper.
// Holds the instruction width, the bubble instruction and the sequencer state encoding.
package jlc_seq_pkg;

  localparam int INSTR_W = 6;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 6'b000000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_BRANCH,
    ST_HALT
  } seq_state_e;

endpackage

// File: rtl/instr_sequencer_if.sv
// Program-load, control and instruction-issue signals between the pin shim/core and the sequencer.
// master drives loads/control and the core's cjump flag; slave is the sequencer itself.
interface instr_sequencer_if
  import jlc_seq_pkg::*;
#(
  parameter int AW = 4
) ();

  logic               wr_en;
  logic [AW-1:0]      wr_addr;
  logic [INSTR_W-1:0] wr_data;
  logic [AW:0]        prog_len;
  logic               start;
  logic               step_mode;
  logic               step;
  logic               cjump;
  logic [INSTR_W-1:0] instr;
  logic               instr_valid;
  logic [AW-1:0]      pc;
  logic               busy;
  logic               halted;

  modport master (
    output wr_en, wr_addr, wr_data, prog_len, start, step_mode, step, cjump,
    input  instr, instr_valid, pc, busy, halted
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, prog_len, start, step_mode, step, cjump,
    output instr, instr_valid, pc, busy, halted
  );

endinterface

// File: rtl/instr_sequencer_prog_mem.sv
// Program store: DEPTH x 6-bit flops, one synchronous write port, one combinational read port.
module seq_prog_mem
  import jlc_seq_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic               clk,
  input  logic               we_i,
  input  logic [AW-1:0]      waddr_i,
  input  logic [INSTR_W-1:0] wdata_i,
  input  logic [AW-1:0]      raddr_i,
  output logic [INSTR_W-1:0] rdata_o
);

  logic [INSTR_W-1:0] mem_q [DEPTH];

  // NOTE: the array has no reset branch; program words only ever become meaningful through writes.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/instr_sequencer.sv
// Feeds the accumulator core one program word per cycle from on-chip storage, following the
// core's cjump flag: a taken branch consumes the next word as its target and costs one bubble.
module instr_sequencer
  import jlc_seq_pkg::*;
#(
  parameter int                 DEPTH = 16,
  parameter int                 AW    = 4,
  parameter logic [INSTR_W-1:0] NOP   = NOP_INSTR
) (
  input logic              clk,
  input logic              rst,
  instr_sequencer_if.slave bus
);

  localparam logic [AW:0] LEN_MAX = {1'b1, {AW{1'b0}}};

  seq_state_e         state_q, state_d;
  logic [AW:0]        pc_q, pc_d, len_q, len_d, pc_inc;
  logic [INSTR_W-1:0] instr_q, instr_d, rd_data, first_word;
  logic               valid_q, valid_d;
  logic               mem_we, advance;
  logic [AW-1:0]      rd_addr;

  assign pc_inc  = pc_q + 1'b1;
  assign advance = !bus.step_mode || bus.step;
  assign mem_we  = bus.wr_en && (state_q == ST_IDLE || state_q == ST_HALT);

  // RUN looks one word ahead (next word or branch operand); BRANCH fetches the target held in pc.
  always_comb begin
    case (state_q)
      ST_RUN:    rd_addr = pc_inc[AW-1:0];
      ST_BRANCH: rd_addr = pc_q[AW-1:0];
      default:   rd_addr = '0;
    endcase
  end

  seq_prog_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk     (clk),
    .we_i    (mem_we),
    .waddr_i (bus.wr_addr),
    .wdata_i (bus.wr_data),
    .raddr_i (rd_addr),
    .rdata_o (rd_data)
  );

  // A write landing on word 0 in the start cycle must be seen by the run it launches.
  assign first_word = (bus.wr_en && bus.wr_addr == '0) ? bus.wr_data : rd_data;

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    len_d   = len_q;
    instr_d = instr_q;
    valid_d = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (valid_q && bus.cjump) begin
          instr_d = NOP;
          if (pc_inc == len_q) begin
            state_d = ST_HALT;
          end else begin
            state_d = ST_BRANCH;
            pc_d    = {1'b0, rd_data[AW-1:0]};
          end
        end else if (advance) begin
          if (pc_inc == len_q) begin
            state_d = ST_HALT;
            instr_d = NOP;
          end else begin
            instr_d = rd_data;
            valid_d = 1'b1;
            pc_d    = pc_inc;
          end
        end
      end
      ST_BRANCH: begin
        instr_d = NOP;
        if (advance) begin
          if (pc_q >= len_q) begin
            state_d = ST_HALT;
          end else begin
            instr_d = rd_data;
            valid_d = 1'b1;
            state_d = ST_RUN;
          end
        end
      end
      default: begin
        instr_d = NOP;
        if (bus.start) begin
          len_d   = (bus.prog_len == '0) ? LEN_MAX : bus.prog_len;
          pc_d    = '0;
          instr_d = first_word;
          valid_d = 1'b1;
          state_d = ST_RUN;
        end
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      len_q   <= '0;
      instr_q <= NOP;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      len_q   <= len_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

  assign bus.instr       = instr_q;
  assign bus.instr_valid = valid_q;
  assign bus.pc          = pc_q[AW-1:0];
  assign bus.busy        = (state_q == ST_RUN) || (state_q == ST_BRANCH);
  assign bus.halted      = (state_q == ST_HALT);

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: issued words are scored against an expectation queue
// filled as each program run is set up; control-state checks are made inline.
module tb_instr_sequencer;

  typedef struct {
    logic [5:0] instr;
    logic [3:0] pc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  instr_sequencer_if #(.AW(4)) bus ();

  instr_sequencer #(.DEPTH(16), .AW(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push(input logic [5:0] i, input logic [3:0] p);
    sb_q.push_back('{instr: i, pc: p});
  endtask

  task automatic wr(input logic [3:0] a, input logic [5:0] d);
    bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d;
    tick();
    bus.wr_en = 1'b0;
  endtask

  task automatic start_run(input logic [4:0] len);
    bus.prog_len = len; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_halt(input string tag, input int budget);
    int n = 0;
    while (!bus.halted && n < budget) begin
      tick();
      n++;
    end
    check(tag, bus.halted, 1'b1);
  endtask

  task automatic idle_state(input string tag);
    check({tag, "_instr"}, bus.instr, 6'h00);
    check({tag, "_valid"}, bus.instr_valid, 1'b0);
    check({tag, "_pc"}, bus.pc, 4'h0);
    check({tag, "_busy"}, bus.busy, 1'b0);
    check({tag, "_halted"}, bus.halted, 1'b0);
  endtask

  // Scoreboard: every valid issue must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (bus.instr_valid) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_valid", bus.instr_valid, 1'b0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("sb_instr", bus.instr, e.instr);
        check("sb_pc", bus.pc, e.pc);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  initial begin
    int vcnt;
    bus.wr_en = 0; bus.wr_addr = 0; bus.wr_data = 0; bus.prog_len = 0;
    bus.start = 0; bus.step_mode = 0; bus.step = 0; bus.cjump = 0;
    tick(); tick();
    rst = 1'b0;
    idle_state("reset");

    // Linear run of four words, issued on consecutive cycles, then HALT.
    for (int i = 0; i < 4; i++) wr(4'(i), 6'(i + 1));
    for (int i = 0; i < 4; i++) push(6'(i + 1), 4'(i));
    start_run(5'd4);
    for (int i = 0; i < 4; i++) begin
      check("lin_valid", bus.instr_valid, 1'b1);
      tick();
    end
    check("lin_halted", bus.halted, 1'b1);
    check("lin_halt_instr", bus.instr, 6'h00);
    check("lin_halt_valid", bus.instr_valid, 1'b0);
    check("lin_drain", sb_q.size(), 0);

    // prog_len of 0 runs the full DEPTH of 16 words.
    for (int i = 0; i < 16; i++) wr(4'(i), 6'(i * 3 + 1));
    for (int i = 0; i < 16; i++) push(6'(i * 3 + 1), 4'(i));
    start_run(5'd0);
    wait_halt("full_halt", 40);
    check("full_drain", sb_q.size(), 0);

    // Branch taken: 07 at pc 1, operand 08 at pc 2, target word 11 at pc 8.
    begin
      logic [5:0] prog [10] = '{6'h05, 6'h07, 6'h08, 6'h0A, 6'h0B,
                                6'h0C, 6'h0D, 6'h0E, 6'h11, 6'h12};
      for (int i = 0; i < 10; i++) wr(4'(i), prog[i]);
    end
    push(6'h05, 4'd0); push(6'h07, 4'd1); push(6'h11, 4'd8); push(6'h12, 4'd9);
    start_run(5'd10);
    tick();
    bus.cjump = 1'b1;
    tick();
    bus.cjump = 1'b0;
    check("br_bubble_valid", bus.instr_valid, 1'b0);
    check("br_bubble_instr", bus.instr, 6'h00);
    check("br_bubble_busy", bus.busy, 1'b1);
    wait_halt("br_halt", 20);
    check("br_drain", sb_q.size(), 0);

    // Branch target 0F is beyond length 10: bubble, then HALT with nothing issued.
    wr(4'd2, 6'h0F);
    push(6'h05, 4'd0); push(6'h07, 4'd1);
    start_run(5'd10);
    tick();
    bus.cjump = 1'b1;
    tick();
    bus.cjump = 1'b0;
    check("oor_bubble_busy", bus.busy, 1'b1);
    tick();
    check("oor_halted", bus.halted, 1'b1);
    tick(); tick(); tick();
    check("oor_drain", sb_q.size(), 0);

    // Branch whose operand would sit at address == length halts at once.
    push(6'h05, 4'd0); push(6'h07, 4'd1);
    start_run(5'd2);
    tick();
    bus.cjump = 1'b1;
    tick();
    bus.cjump = 1'b0;
    check("lastop_halted", bus.halted, 1'b1);
    check("lastop_busy", bus.busy, 1'b0);
    check("lastop_drain", sb_q.size(), 0);

    // Writes during RUN are dropped; a write in the start cycle is honoured.
    for (int i = 0; i < 4; i++) wr(4'(i), 6'(i + 1));
    for (int i = 0; i < 4; i++) push(6'(i + 1), 4'(i));
    start_run(5'd4);
    bus.wr_en = 1'b1; bus.wr_addr = 4'd2; bus.wr_data = 6'h3F;
    tick();
    bus.wr_en = 1'b0;
    wait_halt("wp_halt1", 20);
    for (int i = 0; i < 4; i++) push(6'(i + 1), 4'(i));
    start_run(5'd4);
    wait_halt("wp_halt2", 20);
    check("wp_drain_rerun", sb_q.size(), 0);
    push(6'h01, 4'd0); push(6'h02, 4'd1); push(6'h3F, 4'd2); push(6'h04, 4'd3);
    bus.wr_en = 1'b1; bus.wr_addr = 4'd2; bus.wr_data = 6'h3F;
    start_run(5'd4);
    bus.wr_en = 1'b0;
    wait_halt("wp_halt3", 20);
    push(6'h2A, 4'd0); push(6'h02, 4'd1); push(6'h3F, 4'd2); push(6'h04, 4'd3);
    bus.wr_en = 1'b1; bus.wr_addr = 4'd0; bus.wr_data = 6'h2A;
    start_run(5'd4);
    bus.wr_en = 1'b0;
    wait_halt("wp_halt4", 20);
    check("wp_drain", sb_q.size(), 0);

    // Step mode, length 2: start issues word 0, step at cycle 3 issues word 1, step at 7 halts.
    bus.step_mode = 1'b1;
    bus.prog_len = 5'd2;
    push(6'h2A, 4'd0); push(6'h02, 4'd1);
    vcnt = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      bus.start = (cyc == 0);
      bus.step  = (cyc == 3 || cyc == 7);
      tick();
      if (bus.instr_valid) vcnt++;
      if (cyc == 1) begin
        check("step_hold_instr", bus.instr, 6'h2A);
        check("step_hold_valid", bus.instr_valid, 1'b0);
      end
    end
    bus.start = 1'b0; bus.step = 1'b0; bus.step_mode = 1'b0;
    check("step_valid_cycles", vcnt, 2);
    check("step_halted", bus.halted, 1'b1);
    check("step_drain", sb_q.size(), 0);

    // Reset held two cycles in the middle of a run.
    push(6'h2A, 4'd0); push(6'h02, 4'd1);
    start_run(5'd4);
    tick();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    idle_state("midrst");
    tick();
    idle_state("midrst_after");
    check("midrst_drain", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
